// File: rtl/axi_mst_traffic_gen.sv
// AXI4 master traffic generator: per iteration writes one INCR burst of a
// deterministic pattern, waits for B, reads the burst back and checks every
// beat. Protocol/data errors are counted (saturating) and flagged (sticky).
module axi_mst_traffic_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 4,
    parameter logic [ID_W-1:0]   TXN_ID    = 4'h1,
    parameter int                BURST_LEN = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int                NUM_ITER  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         err_cnt,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                PW        = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [2:0]        AXSIZE    = 3'($clog2(BYTES));
    localparam logic [7:0]        AXLEN     = 8'(BURST_LEN - 1);
    localparam logic [4:0]        LAST_BEAT = 5'(BURST_LEN - 1);
    localparam logic [15:0]       LAST_ITER = 16'(NUM_ITER - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BURST_LEN * BYTES);
    localparam logic [ADDR_W-1:0] BEAT_INC  = ADDR_W'(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] iter_q, iter_d;
    logic [4:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        hit_err;

    // Burst base wraps every 16 iterations; beat address and pattern share beat_q
    // because W and R never overlap.
    logic [ADDR_W-1:0] burst_addr, beat_addr;
    logic [PW-1:0]     pat_full;
    logic [DATA_W-1:0] exp_data;
    assign burst_addr = BASE_ADDR + ADDR_W'(iter_q[3:0]) * STRIDE;
    assign beat_addr  = burst_addr + ADDR_W'(beat_q) * BEAT_INC;
    assign pat_full   = PW'(beat_addr) + PW'(iter_q);
    assign exp_data   = pat_full[DATA_W-1:0];

    // State, counters and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iter_q    <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state, beat/iteration sequencing and error detection
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        beat_d    = beat_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        hit_err   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_AW;
                iter_d    = '0;
                beat_d    = '0;
                err_d     = 1'b0;
                err_cnt_d = '0;
            end
            S_AW: if (awready) begin
                state_d = S_W;
                beat_d  = '0;
            end
            S_W: if (wready) begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_B;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            S_B: if (bvalid) begin
                hit_err = (bresp != 2'b00) || (bid != TXN_ID);
                state_d = S_AR;
            end
            S_AR: if (arready) begin
                state_d = S_R;
                beat_d  = '0;
            end
            S_R: if (rvalid) begin
                // At most one error per beat, whatever combination went wrong
                hit_err = (rdata != exp_data) || (rresp != 2'b00) || (rid != TXN_ID)
                        || (rlast != (beat_q == LAST_BEAT));
                if (rlast || (beat_q == LAST_BEAT)) begin
                    state_d = S_NEXT;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            S_NEXT: begin
                iter_d  = iter_q + 16'd1;
                state_d = (iter_q == LAST_ITER) ? S_DONE : S_AW;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (hit_err) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Channel outputs depend on state only; payloads read zero when not valid
    assign awvalid = (state_q == S_AW);
    assign awid    = awvalid ? TXN_ID : '0;
    assign awaddr  = awvalid ? burst_addr : '0;
    assign awlen   = awvalid ? AXLEN : '0;
    assign awsize  = awvalid ? AXSIZE : '0;
    assign awburst = awvalid ? 2'b01 : 2'b00;

    assign wvalid  = (state_q == S_W);
    assign wdata   = wvalid ? exp_data : '0;
    assign wstrb   = wvalid ? '1 : '0;
    assign wlast   = wvalid && (beat_q == LAST_BEAT);

    assign bready  = (state_q == S_B);

    assign arvalid = (state_q == S_AR);
    assign arid    = arvalid ? TXN_ID : '0;
    assign araddr  = arvalid ? burst_addr : '0;
    assign arlen   = arvalid ? AXLEN : '0;
    assign arsize  = arvalid ? AXSIZE : '0;
    assign arburst = arvalid ? 2'b01 : 2'b00;

    assign rready  = (state_q == S_R);

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_axi_mst_traffic_gen.sv
// Bench for axi_mst_traffic_gen: a behavioural memory slave driven on the
// falling edge, with knobs for stalls, read corruption, B errors and early rlast.
module tb_axi_mst_traffic_gen;
    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, err;
    logic [15:0] err_cnt;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    axi_mst_traffic_gen dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .err_cnt(err_cnt), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pattern, written independently of the RTL
    function automatic logic [31:0] exp_addr(input int it, input int k);
        return 32'h1000 + 32'((it % 16) * 32) + 32'(k * 4);
    endfunction

    // Slave knobs
    bit stall_en    = 0;
    bit bresp_bad   = 0;
    int corrupt_it  = -1;
    int early_it    = -1;

    // Slave state
    logic [31:0] mem [logic [31:0]];
    int  aw_cnt = 0, cur_it = 0, wbeat = 0, rbeat = 0, r_it = 0;
    int  aw_w = 0, w_w = 0, ar_w = 0;
    bit  b_pend = 0, r_act = 0, w_open = 0;
    logic [31:0] ar_base, aw_hold, w_hold, ar_hold;
    logic        wl_hold;

    // Falling-edge slave: everything decided here is what the next rising edge sees
    initial begin
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                {awready, wready, bvalid, arready, rvalid, rlast} = '0;
                b_pend = 0; r_act = 0; w_open = 0;
                aw_w = 0; w_w = 0; ar_w = 0; wbeat = 0; rbeat = 0;
                continue;
            end
            // B
            bvalid = b_pend; bid = 4'h1; bresp = bresp_bad ? 2'b10 : 2'b00;
            if (bvalid && bready) b_pend = 0;
            // R
            rvalid = r_act; rid = 4'h1; rresp = 2'b00;
            if (r_act) begin
                logic [31:0] a, d;
                a = ar_base + 32'(rbeat * 4);
                d = mem.exists(a) ? mem[a] : 32'h0;
                if (r_it == corrupt_it && rbeat == 5) d = d ^ 32'h1;
                rdata = d;
                rlast = (rbeat == 7) || (r_it == early_it && rbeat == 3);
                if (rready) begin
                    if (rlast) r_act = 0;
                    else rbeat++;
                end
            end else begin
                rlast = 1'b0; rdata = '0;
            end
            // AW
            awready = 1'b0;
            if (awvalid) begin
                if (aw_w > 0) chk("aw_stable", awaddr, aw_hold);
                aw_hold = awaddr;
                if (stall_en && aw_w < 3) aw_w++;
                else begin
                    awready = 1'b1; aw_w = 0;
                    chk("awaddr", awaddr, exp_addr(aw_cnt, 0));
                    chk("aw_ctl", {awid, awlen, awsize, awburst}, {4'h1, 8'd7, 3'd2, 2'b01});
                    if (aw_cnt == 3) chk("it3_awaddr", awaddr, 32'h1060);
                    cur_it = aw_cnt; aw_cnt++; wbeat = 0; w_open = 1;
                end
            end
            // W
            wready = 1'b0;
            if (wvalid) begin
                chk("w_after_aw", w_open, 1);
                if (w_w > 0) chk("w_stable", {wl_hold, w_hold}, {wlast, wdata});
                w_hold = wdata; wl_hold = wlast;
                if (stall_en && w_w < 3) w_w++;
                else begin
                    wready = 1'b1; w_w = 0;
                    chk("wdata", wdata, exp_addr(cur_it, wbeat) + 32'(cur_it));
                    chk("wlast_strb", {wlast, wstrb}, {(wbeat == 7), 4'hF});
                    if (cur_it == 3 && wbeat == 0) chk("it3_wdata0", wdata, 32'h1063);
                    mem[exp_addr(cur_it, wbeat)] = wdata;
                    if (wbeat == 7) begin b_pend = 1; w_open = 0; end
                    wbeat++;
                end
            end
            // AR
            arready = 1'b0;
            if (arvalid) begin
                if (ar_w > 0) chk("ar_stable", araddr, ar_hold);
                ar_hold = araddr;
                if (stall_en && ar_w < 3) ar_w++;
                else begin
                    arready = 1'b1; ar_w = 0;
                    chk("araddr", araddr, exp_addr(cur_it, 0));
                    chk("ar_ctl", {arid, arlen, arsize, arburst}, {4'h1, 8'd7, 3'd2, 2'b01});
                    ar_base = araddr; r_act = 1; rbeat = 0; r_it = cur_it;
                end
            end
        end
    end

    // One run: start pulse, bounded wait for done, then final status
    task automatic run_case(input string tag, input int exp_cnt, input int exp_cyc,
                            input bit extra_start);
        int cyc;
        @(negedge clk);
        aw_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (extra_start && cyc == 50);
        end
        start = 1'b0;
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc, exp_cyc);
            chk({tag, "_err_cnt"}, err_cnt, exp_cnt);
            chk({tag, "_err"}, err, (exp_cnt != 0));
            chk({tag, "_busy_done"}, busy, 0);
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_err_hold"}, err_cnt, exp_cnt);
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_status", {busy, done, err}, 3'b0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_payload", {awaddr, araddr, wdata}, 96'h0);
        rst = 1'b0;

        run_case("clean", 0, 320, 0);

        stall_en = 1;
        run_case("stall", 0, -1, 0);
        stall_en = 0;

        corrupt_it = 2;
        run_case("corrupt", 1, 320, 0);
        corrupt_it = -1;

        bresp_bad = 1;
        run_case("bresp", 16, 320, 0);
        bresp_bad = 0;

        early_it = 1;
        run_case("early_rlast", 1, -1, 0);
        early_it = -1;

        // Abort mid-write after errors have accumulated
        bresp_bad = 1;
        @(negedge clk);
        aw_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(aw_cnt == 2 && wbeat == 4) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reach", (guard < 2000), 1);
        chk("rst_mid_err_pre", (err_cnt != 0), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_mid_status", {busy, done, err}, 3'b0);
        chk("rst_mid_err_cnt", err_cnt, 0);
        rst = 1'b0;
        bresp_bad = 0;

        run_case("after_rst", 0, 320, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
